// File: rtl/voting_pkg.sv
`default_nettype none
// ============================================================================
// Module : voting_pkg
// Shared state encoding and display constants for the result sequencer.
// Rev    : 1.0
// ============================================================================
package voting_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      SHOW = 2'd2
   } state_t;

   localparam int unsigned NUM_CAND    = 4;
   localparam logic [2:0]  SLOT_WINNER = 3'd4;
   localparam logic [7:0]  LED_TIE     = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ============================================================================
// Module : dwell_timer
// Free-running slot timer: one-cycle tick every DWELL enabled cycles.
// Rev    : 1.0
// ============================================================================
module dwell_timer #(
   parameter int unsigned DWELL = 50_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [31:0] LAST = 32'(DWELL - 1);

   logic [31:0] cnt_q, cnt_d;

   always_comb begin
      tick  = en && !clr && (cnt_q == LAST);
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tick ? '0 : cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/result_sequencer.sv
`default_nettype none
// ============================================================================
// Module : result_sequencer
// Snapshots four vote counts, scans for winner/tie/total, cycles the LED bus.
// Rev    : 1.0
// ============================================================================
module result_sequencer
   import voting_pkg::*;
#(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned DWELL = 50_000_000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               mode,
   input  logic [CNT_W-1:0]   cand1_count,
   input  logic [CNT_W-1:0]   cand2_count,
   input  logic [CNT_W-1:0]   cand3_count,
   input  logic [CNT_W-1:0]   cand4_count,
   output logic [7:0]         led,
   output logic [1:0]         winner,
   output logic               tie,
   output logic [CNT_W+1:0]   total,
   output logic               result_valid,
   output logic [2:0]         slot
);

   localparam int unsigned TOT_W = CNT_W + 2;

   state_t             state_q, state_d;
   logic               mode_dly_q;
   logic [CNT_W-1:0]   snap_q [NUM_CAND];
   logic [CNT_W-1:0]   snap_d [NUM_CAND];
   logic [CNT_W-1:0]   max_q, max_d;
   logic [1:0]         idx_q, idx_d;
   logic               scan_tie_q, scan_tie_d;
   logic [TOT_W-1:0]   acc_q, acc_d;
   logic [1:0]         i_q, i_d;
   logic [1:0]         winner_q, winner_d;
   logic               tie_q, tie_d;
   logic [TOT_W-1:0]   total_q, total_d;
   logic               valid_q, valid_d;
   logic [2:0]         slot_q, slot_d;
   logic [CNT_W-1:0]   cur;
   logic               start;
   logic               tick;

   dwell_timer #(.DWELL(DWELL)) u_dwell (
      .clock (clock),
      .reset (reset),
      .en    (state_q == SHOW),
      .clr   (!mode),
      .tick  (tick)
   );

   always_comb begin
      state_d    = state_q;
      snap_d     = snap_q;
      max_d      = max_q;
      idx_d      = idx_q;
      scan_tie_d = scan_tie_q;
      acc_d      = acc_q;
      i_d        = i_q;
      winner_d   = winner_q;
      tie_d      = tie_q;
      total_d    = total_q;
      valid_d    = valid_q;
      slot_d     = slot_q;
      cur        = snap_q[i_q];
      start      = mode && !mode_dly_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               snap_d     = '{cand1_count, cand2_count, cand3_count, cand4_count};
               max_d      = '0;
               idx_d      = '0;
               scan_tie_d = 1'b0;
               acc_d      = '0;
               i_d        = '0;
               state_d    = SCAN;
            end
         end
         SCAN: begin
            acc_d = acc_q + TOT_W'(cur);
            if (i_q == 2'd0) begin
               max_d      = cur;
               idx_d      = 2'd0;
               scan_tie_d = 1'b0;
            end else if (cur > max_q) begin
               max_d      = cur;
               idx_d      = i_q;
               scan_tie_d = 1'b0;
            end else if (cur == max_q) begin
               scan_tie_d = 1'b1;
            end
            // Publish from the _d values so the last candidate is included.
            if (i_q == 2'd3) begin
               state_d  = SHOW;
               winner_d = idx_d;
               tie_d    = scan_tie_d;
               total_d  = acc_d;
               valid_d  = 1'b1;
               slot_d   = 3'd0;
            end else begin
               i_d = i_q + 2'd1;
            end
         end
         SHOW: begin
            if (tick) begin
               slot_d = (slot_q == SLOT_WINNER) ? 3'd0 : slot_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (!mode) begin
         state_d  = IDLE;
         winner_d = '0;
         tie_d    = 1'b0;
         total_d  = '0;
         valid_d  = 1'b0;
         slot_d   = '0;
      end
   end

   always_comb begin
      led = 8'h00;
      if (state_q == SHOW) begin
         if (slot_q == SLOT_WINNER) begin
            led = tie_q ? LED_TIE : (8'h01 << winner_q);
         end else begin
            led = 8'(snap_q[slot_q[1:0]]);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         mode_dly_q <= 1'b0;
         snap_q     <= '{default: '0};
         max_q      <= '0;
         idx_q      <= '0;
         scan_tie_q <= 1'b0;
         acc_q      <= '0;
         i_q        <= '0;
         winner_q   <= '0;
         tie_q      <= 1'b0;
         total_q    <= '0;
         valid_q    <= 1'b0;
         slot_q     <= '0;
      end else begin
         state_q    <= state_d;
         mode_dly_q <= mode;
         snap_q     <= snap_d;
         max_q      <= max_d;
         idx_q      <= idx_d;
         scan_tie_q <= scan_tie_d;
         acc_q      <= acc_d;
         i_q        <= i_d;
         winner_q   <= winner_d;
         tie_q      <= tie_d;
         total_q    <= total_d;
         valid_q    <= valid_d;
         slot_q     <= slot_d;
      end
   end

   assign winner       = winner_q;
   assign tie          = tie_q;
   assign total        = total_q;
   assign result_valid = valid_q;
   assign slot         = slot_q;

endmodule
`default_nettype wire
